// File: rtl/tft_spi.sv
// tft_spi: free-running, write-only 16-bit SPI master (mode 0) for the TFT
// display controller. Each frame loads the parallel word once, then shifts it
// out MSB-first. Frames run back-to-back with no handshake.
module tft_spi #(
  parameter int CLK_DIV = 2
) (
  input  logic        MasterCLK,
  input  logic        sys_rst_n,
  input  logic [15:0] data,
  output logic [15:0] OutputData,
  output logic        SPI_MOSI,
  output logic        SPI_CLK
);

  // div_cnt only has to reach CLK_DIV-1; keep at least one bit for CLK_DIV=1
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [15:0]      shift_reg;
  logic             div_end;

  assign div_end = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Frame sequencer: one LOAD cycle, then 16 SPI_CLK periods of shifting
  always_ff @(posedge MasterCLK or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_LOAD;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      OutputData <= '0;
      SPI_MOSI   <= 1'b0;
      SPI_CLK    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          // data is sampled here only; MSB goes out immediately so it has the
          // whole low phase to settle before the first rising edge
          shift_reg  <= data;
          OutputData <= data;
          SPI_MOSI   <= data[15];
          SPI_CLK    <= 1'b0;
          div_cnt    <= '0;
          bit_cnt    <= '0;
          state      <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            SPI_CLK <= ~SPI_CLK;
            // MOSI only moves on the high->low transition (CPHA=0)
            if (SPI_CLK) begin
              if (bit_cnt == 4'd15) begin
                state <= ST_LOAD;
              end else begin
                shift_reg <= shift_reg << 1;
                SPI_MOSI  <= shift_reg[14];
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_spi.sv
// tb_tft_spi: scoreboard bench for tft_spi. An independent frame-timing model
// pushes the word present at each expected LOAD; the monitor rebuilds the
// serial word from SPI_CLK rising edges and pops/compares it.
module tb_tft_spi;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;

  logic [15:0] od2, od1;
  logic        mosi2, mosi1;
  logic        sck2, sck1;

  int n_cmp = 0;
  int n_err = 0;

  localparam int FRAME2 = 1 + 32 * 2;
  localparam int FRAME1 = 1 + 32 * 1;

  tft_spi #(.CLK_DIV(2)) dut (
    .MasterCLK (clk),
    .sys_rst_n (rst_n),
    .data      (data),
    .OutputData(od2),
    .SPI_MOSI  (mosi2),
    .SPI_CLK   (sck2)
  );

  tft_spi #(.CLK_DIV(1)) dut1 (
    .MasterCLK (clk),
    .sys_rst_n (rst_n),
    .data      (data),
    .OutputData(od1),
    .SPI_MOSI  (mosi1),
    .SPI_CLK   (sck1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and monitor for the CLK_DIV=2 instance
  logic [15:0] exp_q[$];
  logic [15:0] cur_word;
  logic [15:0] rx_word;
  logic [15:0] popped;
  int          mcount = -1;
  int          nbits = 0;
  int          frames = 0;
  logic        prev_clk = 1'b0;
  logic        prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_sck", {31'd0, sck2}, 32'd0);
      check("rst_mosi", {31'd0, mosi2}, 32'd0);
      check("rst_outdata", {16'd0, od2}, 32'd0);
      mcount = -1; nbits = 0; frames = 0;
      prev_clk = 1'b0; prev_mosi = 1'b0;
      exp_q.delete();
    end else begin
      mcount++;
      if (mcount % FRAME2 == 0) begin
        if (frames > 0) check("bits_per_frame", nbits, 16);
        nbits = 0;
        rx_word = '0;
        exp_q.delete();
        exp_q.push_back(data);
        cur_word = data;
        frames++;
        check("sck_low_at_load", {31'd0, sck2}, 32'd0);
        check("mosi_msb_at_load", {31'd0, mosi2}, {31'd0, data[15]});
      end
      check("outdata", {16'd0, od2}, {16'd0, cur_word});
      if (sck2 && !prev_clk) begin
        check("mosi_stable", {31'd0, mosi2}, {31'd0, prev_mosi});
        if (nbits < 16 && exp_q.size() > 0) begin
          check("mosi_bit", {31'd0, mosi2}, {31'd0, exp_q[0][15 - nbits]});
          rx_word = {rx_word[14:0], mosi2};
        end
        nbits++;
        if (nbits == 16 && exp_q.size() > 0) begin
          popped = exp_q.pop_front();
          check("frame_word", {16'd0, rx_word}, {16'd0, popped});
        end
      end
      prev_clk  = sck2;
      prev_mosi = mosi2;
    end
  end

  // Lighter monitor for the CLK_DIV=1 instance: frame length and rising edges
  int   m1 = -1;
  int   n1 = 0;
  int   f1 = 0;
  logic pc1 = 1'b0;
  logic pm1 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_sck_d1", {31'd0, sck1}, 32'd0);
      m1 = -1; n1 = 0; f1 = 0; pc1 = 1'b0; pm1 = 1'b0;
    end else begin
      m1++;
      if (m1 % FRAME1 == 0) begin
        if (f1 > 0) check("bits_per_frame_d1", n1, 16);
        n1 = 0;
        f1++;
        check("sck_low_at_load_d1", {31'd0, sck1}, 32'd0);
        check("outdata_d1", {16'd0, od1}, {16'd0, data});
      end
      if (sck1 && !pc1) begin
        check("mosi_stable_d1", {31'd0, mosi1}, {31'd0, pm1});
        n1++;
      end
      pc1 = sck1;
      pm1 = mosi1;
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    data  = 16'hFFFF;
    #1 rst_n = 1'b0;
    #1;
    // Reset acts without any clock edge
    check("async_rst_sck", {31'd0, sck2}, 32'd0);
    check("async_rst_mosi", {31'd0, mosi2}, 32'd0);
    check("async_rst_outdata", {16'd0, od2}, 32'd0);
    wait_cycles(5);

    // Known pattern, two full frames
    data = 16'hA5C3;
    release_reset();
    wait_cycles(2 * FRAME2 + 5);

    // Mid-frame change must not disturb the frame in flight
    @(negedge clk); #1 data = 16'h0000;
    wait_cycles(FRAME2 + 20);
    @(negedge clk); #1 data = 16'hFFFF;
    wait_cycles(2 * FRAME2 + 10);

    // Asynchronous reset pulse in the middle of a frame
    data = 16'h8001;
    wait_cycles(17);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("midframe_rst_sck", {31'd0, sck2}, 32'd0);
    check("midframe_rst_mosi", {31'd0, mosi2}, 32'd0);
    check("midframe_rst_outdata", {16'd0, od2}, 32'd0);
    check("midframe_rst_outdata_d1", {16'd0, od1}, 32'd0);
    wait_cycles(3);
    release_reset();
    wait_cycles(3 * FRAME2 + 5);

    // Long random-data run
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1 data = 16'($urandom);
    end
    wait_cycles(2 * FRAME2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
